// File: rtl/l2_flush_engine_pkg.sv
// Shared constants and FSM state type for the L2 flush/writeback sequencer.
package l2_flush_engine_pkg;

  localparam int unsigned SETS_DEF    = 256;
  localparam int unsigned WAYS_DEF    = 8;
  localparam int unsigned WORDS_DEF   = 2;
  localparam int unsigned WORD_W_DEF  = 64;
  localparam int unsigned STATE_W_DEF = 3;
  localparam int unsigned TAG_W_DEF   = 20;
  localparam int unsigned ST_I_DEF    = 0;
  localparam int unsigned ST_O_DEF    = 2;

  typedef enum logic [2:0] {
    FL_IDLE,
    FL_DRAIN,
    FL_READ,
    FL_EVAL,
    FL_WB,
    FL_INVAL,
    FL_DONE
  } flush_state_t;

endpackage

// File: rtl/l2_flush_cursor.sv
// Set/way walk counter; way is the low-order digit so a way wrap carries into set.
module l2_flush_cursor
  import l2_flush_engine_pkg::*;
#(
  parameter int unsigned SETS = SETS_DEF,
  parameter int unsigned WAYS = WAYS_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    advance,
  output logic [$clog2(SETS)-1:0] set,
  output logic [$clog2(WAYS)-1:0] way,
  output logic                    is_last
);

  // SETS and WAYS are powers of two, so the last line is all-ones in both fields.
  assign is_last = (&set) & (&way);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      set <= '0;
      way <= '0;
    end else if (advance) begin
      {set, way} <= {set, way} + 1'b1;
    end
  end

endmodule

// File: rtl/l2_flush_engine.sv
// Flush sequencer: drains MSHRs, walks every (set, way), writes back owned words
// and invalidates selected lines through the shared lmem ports.
module l2_flush_engine
  import l2_flush_engine_pkg::*;
#(
  parameter int unsigned SETS    = SETS_DEF,
  parameter int unsigned WAYS    = WAYS_DEF,
  parameter int unsigned WORDS   = WORDS_DEF,
  parameter int unsigned WORD_W  = WORD_W_DEF,
  parameter int unsigned STATE_W = STATE_W_DEF,
  parameter int unsigned TAG_W   = TAG_W_DEF,
  parameter int unsigned ST_I    = ST_I_DEF,
  parameter int unsigned ST_O    = ST_O_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush_valid,
  input  logic                          flush_is_all,
  output logic                          flush_ready,
  input  logic                          mshr_empty,
  input  logic                          lmem_grant,
  output logic                          ongoing_flush,
  output logic                          rd_en,
  output logic [$clog2(SETS)-1:0]       rd_set,
  output logic [$clog2(WAYS)-1:0]       rd_way,
  input  logic [TAG_W-1:0]              rd_tag,
  input  logic                          rd_hprot,
  input  logic [WORDS*STATE_W-1:0]      rd_state,
  input  logic [WORDS*WORD_W-1:0]       rd_line,
  output logic                          wb_valid,
  input  logic                          wb_ready,
  output logic [TAG_W+$clog2(SETS)-1:0] wb_addr,
  output logic [WORDS*WORD_W-1:0]       wb_line,
  output logic [WORDS-1:0]              wb_word_mask,
  output logic                          st_wr_en,
  output logic [$clog2(SETS)-1:0]       st_wr_set,
  output logic [$clog2(WAYS)-1:0]       st_wr_way,
  output logic                          flush_done
);

  localparam int unsigned SET_W = $clog2(SETS);
  localparam int unsigned WAY_W = $clog2(WAYS);

  flush_state_t              state;
  logic                      is_all_q;
  logic [TAG_W-1:0]          tag_q;
  logic [WORDS-1:0]          mask_q;
  logic [WORDS*WORD_W-1:0]   line_q;

  logic [SET_W-1:0]          cur_set;
  logic [WAY_W-1:0]          cur_way;
  logic                      is_last;
  logic                      advance;
  logic                      clear;
  logic [WORDS-1:0]          eval_mask;
  logic                      any_valid;
  logic                      selected;

  always_comb begin
    eval_mask = '0;
    any_valid = 1'b0;
    for (int unsigned w = 0; w < WORDS; w++) begin
      eval_mask[w] = (rd_state[w*STATE_W +: STATE_W] == STATE_W'(ST_O));
      if (rd_state[w*STATE_W +: STATE_W] != STATE_W'(ST_I)) any_valid = 1'b1;
    end
    selected = any_valid & (is_all_q | rd_hprot);
  end

  assign advance = ((state == FL_EVAL) && !selected) || (state == FL_INVAL);
  assign clear   = (state == FL_IDLE) && flush_valid;

  l2_flush_cursor #(
    .SETS (SETS),
    .WAYS (WAYS)
  ) u_cursor (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .advance (advance),
    .set     (cur_set),
    .way     (cur_way),
    .is_last (is_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FL_IDLE;
      is_all_q <= 1'b0;
      tag_q    <= '0;
      mask_q   <= '0;
      line_q   <= '0;
    end else begin
      case (state)
        FL_IDLE: begin
          if (flush_valid) begin
            is_all_q <= flush_is_all;
            state    <= FL_DRAIN;
          end
        end
        FL_DRAIN: if (mshr_empty) state <= FL_READ;
        FL_READ:  if (lmem_grant) state <= FL_EVAL;
        FL_EVAL: begin
          tag_q  <= rd_tag;
          mask_q <= eval_mask;
          line_q <= rd_line;
          if (!selected)      state <= is_last ? FL_DONE : FL_READ;
          else if (|eval_mask) state <= FL_WB;
          else                state <= FL_INVAL;
        end
        FL_WB:    if (wb_ready) state <= FL_INVAL;
        FL_INVAL: state <= is_last ? FL_DONE : FL_READ;
        FL_DONE:  state <= FL_IDLE;
        default:  state <= FL_IDLE;
      endcase
    end
  end

  // Cursor only moves after INVAL, so it still names the line being written back/invalidated.
  assign flush_ready   = (state == FL_IDLE);
  assign ongoing_flush = (state != FL_IDLE);
  assign rd_en         = (state == FL_READ) && lmem_grant;
  assign rd_set        = cur_set;
  assign rd_way        = cur_way;
  assign wb_valid      = (state == FL_WB);
  assign wb_addr       = {tag_q, cur_set};
  assign wb_line       = line_q;
  assign wb_word_mask  = mask_q;
  assign st_wr_en      = (state == FL_INVAL);
  assign st_wr_set     = cur_set;
  assign st_wr_way     = cur_way;
  assign flush_done    = (state == FL_DONE);

endmodule

// File: tb/tb_l2_flush_engine.sv
// Directed bench for l2_flush_engine on a 4-set, 2-way cache with a behavioural lmem model.
module tb_l2_flush_engine;

  localparam int unsigned SETS = 4, WAYS = 2, WORDS = 2, WORD_W = 64;
  localparam int unsigned STATE_W = 3, TAG_W = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush_valid = 1'b0, flush_is_all = 1'b0, mshr_empty = 1'b1, lmem_grant = 1'b1;
  logic wb_ready = 1'b1;
  logic flush_ready, ongoing_flush, rd_en, wb_valid, st_wr_en, flush_done;
  logic [1:0]   rd_set, st_wr_set;
  logic [0:0]   rd_way, st_wr_way;
  logic [TAG_W-1:0]  rd_tag = '0;
  logic              rd_hprot = 1'b0;
  logic [5:0]        rd_state = '0;
  logic [127:0]      rd_line = '0;
  logic [21:0]       wb_addr;
  logic [127:0]      wb_line;
  logic [1:0]        wb_word_mask;

  logic [TAG_W-1:0] mem_tag   [0:7];
  logic             mem_hprot [0:7];
  logic [5:0]       mem_state [0:7];
  logic [127:0]     mem_line  [0:7];

  int n_checks = 0, n_fail = 0;
  int rd_cnt = 0, bad_rd = 0, wb_cnt = 0, st_cnt = 0, done_cnt = 0;
  logic [21:0]  last_addr = '0;
  logic [1:0]   last_mask = '0;
  logic [127:0] last_line = '0;
  logic [2:0]   last_st = '0;

  localparam logic [127:0] LINE_A = {64'hCAFE_F00D_DEAD_BEEF, 64'h0123_4567_89AB_CDEF};

  always #5 clk = ~clk;

  l2_flush_engine #(
    .SETS(SETS), .WAYS(WAYS), .WORDS(WORDS), .WORD_W(WORD_W),
    .STATE_W(STATE_W), .TAG_W(TAG_W), .ST_I(0), .ST_O(2)
  ) dut (
    .clk(clk), .rst(rst), .flush_valid(flush_valid), .flush_is_all(flush_is_all),
    .flush_ready(flush_ready), .mshr_empty(mshr_empty), .lmem_grant(lmem_grant),
    .ongoing_flush(ongoing_flush), .rd_en(rd_en), .rd_set(rd_set), .rd_way(rd_way),
    .rd_tag(rd_tag), .rd_hprot(rd_hprot), .rd_state(rd_state), .rd_line(rd_line),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_line(wb_line),
    .wb_word_mask(wb_word_mask), .st_wr_en(st_wr_en), .st_wr_set(st_wr_set),
    .st_wr_way(st_wr_way), .flush_done(flush_done)
  );

  // lmem model: read data is presented after rd_en and held until the next read.
  always @(negedge clk) begin
    if (rd_en) begin
      rd_cnt = rd_cnt + 1;
      if (!lmem_grant) bad_rd = bad_rd + 1;
      rd_tag   <= mem_tag[{rd_set, rd_way}];
      rd_hprot <= mem_hprot[{rd_set, rd_way}];
      rd_state <= mem_state[{rd_set, rd_way}];
      rd_line  <= mem_line[{rd_set, rd_way}];
    end
    if (wb_valid && wb_ready) begin
      wb_cnt    = wb_cnt + 1;
      last_addr = wb_addr;
      last_mask = wb_word_mask;
      last_line = wb_line;
    end
    if (st_wr_en) begin
      st_cnt  = st_cnt + 1;
      last_st = {st_wr_set, st_wr_way};
    end
    if (flush_done) done_cnt = done_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 8; i++) begin
      mem_tag[i] = '0; mem_hprot[i] = 1'b0; mem_state[i] = '0; mem_line[i] = '0;
    end
  endtask

  // Line (2,1): tag 0x3, word0 Owned, word1 Valid.
  task automatic load_line(input logic hprot);
    mem_tag[5]   = 20'h3;
    mem_hprot[5] = hprot;
    mem_state[5] = {3'd1, 3'd2};
    mem_line[5]  = LINE_A;
  endtask

  // cyc counts cycles after the accept cycle; flush_done is expected on the returned cycle.
  task automatic run_flush(input logic is_all, input int mshr_delay, input logic toggle,
                           output int cyc, output int rd_early, output int ong_miss);
    int rd0;
    mshr_empty   = (mshr_delay == 0);
    flush_is_all = is_all;
    flush_valid  = 1'b1;
    @(posedge clk); #1;
    flush_valid = 1'b0;
    rd0 = rd_cnt; cyc = 1; rd_early = 0; ong_miss = 0;
    while (!flush_done && cyc < 400) begin
      if (!ongoing_flush) ong_miss++;
      if (cyc == mshr_delay) begin
        rd_early   = rd_cnt - rd0;
        mshr_empty = 1'b1;
      end
      if (toggle) lmem_grant = ~lmem_grant;
      @(posedge clk); #1;
      cyc++;
    end
    lmem_grant = 1'b1;
    mshr_empty = 1'b1;
    @(posedge clk); #1;
  endtask

  int cyc, rd_early, ong_miss, rd0, wb0, st0, d0, k;
  logic [21:0]  s_addr;
  logic [127:0] s_line;
  logic [1:0]   s_mask;

  initial begin
    clear_mem();
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_flush_ready", flush_ready, 1);
    check_val("rst_ongoing", ongoing_flush, 0);
    check_val("rst_rd_en", rd_en, 0);
    check_val("rst_wb_valid", wb_valid, 0);
    check_val("rst_st_wr_en", st_wr_en, 0);
    check_val("rst_cursor", {rd_set, rd_way}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Empty cache: 1 + 2*8 + 1 cycles.
    rd0 = rd_cnt; wb0 = wb_cnt; st0 = st_cnt; d0 = done_cnt;
    run_flush(1'b1, 0, 1'b0, cyc, rd_early, ong_miss);
    check_val("empty_cycles", cyc, 18);
    check_val("empty_rd_cnt", rd_cnt - rd0, 8);
    check_val("empty_wb_cnt", wb_cnt - wb0, 0);
    check_val("empty_st_cnt", st_cnt - st0, 0);
    check_val("empty_done_pulses", done_cnt - d0, 1);
    check_val("empty_back_idle", flush_ready, 1);

    // Owned line with hprot=1, data-only flush.
    load_line(1'b1);
    rd0 = rd_cnt; wb0 = wb_cnt; st0 = st_cnt;
    run_flush(1'b0, 0, 1'b0, cyc, rd_early, ong_miss);
    check_val("wb_cnt", wb_cnt - wb0, 1);
    check_val("wb_addr", last_addr, 22'hE);
    check_val("wb_mask", last_mask, 2'b01);
    check_val("wb_line", last_line, LINE_A);
    check_val("wb_st_cnt", st_cnt - st0, 1);
    check_val("wb_st_loc", last_st, 3'b101);
    check_val("wb_cycles", cyc, 20);

    // Instruction line (hprot=0): skipped on data-only flush, taken on flush-all.
    load_line(1'b0);
    wb0 = wb_cnt; st0 = st_cnt;
    run_flush(1'b0, 0, 1'b0, cyc, rd_early, ong_miss);
    check_val("hp0_wb_cnt", wb_cnt - wb0, 0);
    check_val("hp0_st_cnt", st_cnt - st0, 0);
    wb0 = wb_cnt; st0 = st_cnt;
    run_flush(1'b1, 0, 1'b0, cyc, rd_early, ong_miss);
    check_val("all_wb_cnt", wb_cnt - wb0, 1);
    check_val("all_st_cnt", st_cnt - st0, 1);
    check_val("all_wb_addr", last_addr, 22'hE);

    // MSHR drain delay of 10 cycles on an empty cache.
    clear_mem();
    rd0 = rd_cnt;
    run_flush(1'b1, 10, 1'b0, cyc, rd_early, ong_miss);
    check_val("mshr_rd_early", rd_early, 0);
    check_val("mshr_ongoing_miss", ong_miss, 0);
    check_val("mshr_cycles", cyc, 27);
    check_val("mshr_rd_cnt", rd_cnt - rd0, 8);

    // Writeback stalled 5 cycles by wb_ready=0.
    load_line(1'b1);
    wb_ready = 1'b0;
    wb0 = wb_cnt; st0 = st_cnt; d0 = done_cnt;
    flush_is_all = 1'b1; flush_valid = 1'b1;
    @(posedge clk); #1;
    flush_valid = 1'b0;
    k = 0;
    while (!wb_valid && k < 100) begin @(posedge clk); #1; k++; end
    check_val("stall_wb_seen", wb_valid, 1);
    s_addr = wb_addr; s_line = wb_line; s_mask = wb_word_mask;
    check_val("stall_addr0", s_addr, 22'hE);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_val("stall_wb_valid", wb_valid, 1);
      check_val("stall_addr", wb_addr, s_addr);
      check_val("stall_line", wb_line, s_line);
      check_val("stall_mask", wb_word_mask, s_mask);
      check_val("stall_no_inval", st_wr_en, 0);
    end
    wb_ready = 1'b1;
    k = 0;
    while (!flush_done && k < 100) begin @(posedge clk); #1; k++; end
    check_val("stall_done", flush_done, 1);
    @(posedge clk); #1;
    check_val("stall_wb_cnt", wb_cnt - wb0, 1);
    check_val("stall_st_cnt", st_cnt - st0, 1);

    // lmem_grant toggled every cycle.
    clear_mem();
    rd0 = rd_cnt;
    run_flush(1'b1, 0, 1'b1, cyc, rd_early, ong_miss);
    check_val("grant_bad_rd", bad_rd, 0);
    check_val("grant_rd_cnt", rd_cnt - rd0, 8);
    check_val("grant_finished", cyc < 400, 1);

    // Reset in the middle of the walk at set 1.
    d0 = done_cnt;
    flush_is_all = 1'b1; flush_valid = 1'b1;
    @(posedge clk); #1;
    flush_valid = 1'b0;
    k = 0;
    while (!(rd_en && rd_set == 2'd1) && k < 100) begin @(posedge clk); #1; k++; end
    check_val("mid_reached_set1", rd_set, 2'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_val("mid_flush_ready", flush_ready, 1);
    check_val("mid_ongoing", ongoing_flush, 0);
    repeat (3) @(posedge clk);
    #1;
    check_val("mid_no_done", done_cnt - d0, 0);

    // Fresh flush after the abort starts at (0,0).
    flush_is_all = 1'b1; flush_valid = 1'b1;
    @(posedge clk); #1;
    flush_valid = 1'b0;
    k = 0;
    while (!rd_en && k < 100) begin @(posedge clk); #1; k++; end
    check_val("restart_rd_en", rd_en, 1);
    check_val("restart_loc", {rd_set, rd_way}, 3'b000);
    k = 0;
    while (!flush_done && k < 100) begin @(posedge clk); #1; k++; end
    check_val("restart_done", flush_done, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
